// File: rtl/serial_adder.sv
// Multi-cycle adder: SUM = A + B + CIN computed DIGIT bits per clock, LSB digit first,
// with a start/busy/done handshake and registered sum, carry-out and signed overflow.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(N) + 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    // Handshake: start is taken only in IDLE or DONE; busy is high exactly while
    // digits are being added; done pulses for the one cycle the new result appears.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic               last_step;
    logic [DIGIT:0]     dig_full;
    logic [WIDTH-1:0]   digit_ext;
    logic [WIDTH-1:0]   work_shift;
    logic               msb_carry;

    assign accept    = start && (state_q == IDLE || state_q == DONE);
    assign last_step = (state_q == RUN) && (cnt_q == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        dbg_state = state_q;
    end

    // Carry into the digit's top bit falls out of its sum bit; on the last digit
    // that is the carry into bit WIDTH-1, used for signed overflow.
    always_comb begin
        dig_full   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
        digit_ext  = WIDTH'(dig_full[DIGIT-1:0]);
        work_shift = (work_q >> DIGIT) | (digit_ext << (WIDTH - DIGIT));
        msb_carry  = dig_full[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
            work_d  = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = dig_full[DIGIT];
            cnt_d   = cnt_q + 1'b1;
            work_d  = work_shift;
            if (last_step) begin
                sum_d  = work_shift;
                cout_d = dig_full[DIGIT];
                ovf_d  = msb_carry ^ dig_full[DIGIT];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (8x1, 4x2, 8x8) driven from directed tables,
// hand-written handshake/reset sequences, an exhaustive 4-bit sweep and a random 8x8 run.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 1: WIDTH=8, DIGIT=1
    logic       s1_start, s1_cin, s1_busy, s1_done, s1_cout, s1_ovf;
    logic [7:0] s1_a, s1_b, s1_sum;
    logic [1:0] s1_state;
    // Instance 2: WIDTH=4, DIGIT=2
    logic       s2_start, s2_cin, s2_busy, s2_done, s2_cout, s2_ovf;
    logic [3:0] s2_a, s2_b, s2_sum;
    logic [1:0] s2_state;
    // Instance 3: WIDTH=8, DIGIT=8
    logic       s3_start, s3_cin, s3_busy, s3_done, s3_cout, s3_ovf;
    logic [7:0] s3_a, s3_b, s3_sum;
    logic [1:0] s3_state;

    logic [9:0] exp_q[$];

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b), .cin(s1_cin),
        .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf),
        .dbg_state(s1_state)
    );
    serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(s2_start), .a(s2_a), .b(s2_b), .cin(s2_cin),
        .busy(s2_busy), .done(s2_done), .sum(s2_sum), .cout(s2_cout), .ovf(s2_ovf),
        .dbg_state(s2_state)
    );
    serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut3 (
        .clk(clk), .rst(rst), .start(s3_start), .a(s3_a), .b(s3_b), .cin(s3_cin),
        .busy(s3_busy), .done(s3_done), .sum(s3_sum), .cout(s3_cout), .ovf(s3_ovf),
        .dbg_state(s3_state)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Starts an op on the 8x1 instance in the current cycle and follows it to DONE.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input logic [7:0] es, input logic ec, input logic eo);
        s1_a = ta; s1_b = tb_v; s1_cin = tc; s1_start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            s1_start = 1'b0;
            s1_a = 8'($urandom);
            s1_b = 8'($urandom);
            s1_cin = 1'($urandom);
            check($sformatf("w8 busy c%0d", k), 32'(s1_busy), 32'(k <= 8));
            check($sformatf("w8 done c%0d", k), 32'(s1_done), 32'(k == 9));
        end
        check($sformatf("w8 sum %h+%h+%b", ta, tb_v, tc), 32'(s1_sum), 32'(es));
        check($sformatf("w8 cout %h+%h+%b", ta, tb_v, tc), 32'(s1_cout), 32'(ec));
        check($sformatf("w8 ovf %h+%h+%b", ta, tb_v, tc), 32'(s1_ovf), 32'(eo));
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc);
        logic [4:0] full;
        logic       eo;
        full = {1'b0, ta} + {1'b0, tb_v} + {4'b0, tc};
        eo   = (ta[3] == tb_v[3]) && (full[3] != ta[3]);
        s2_a = ta; s2_b = tb_v; s2_cin = tc; s2_start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            s2_start = 1'b0;
            check($sformatf("w4 busy/done c%0d", k), 32'({s2_busy, s2_done}),
                  32'({k <= 2, k == 3}));
        end
        check($sformatf("w4 %h+%h+%b {cout,ovf,sum}", ta, tb_v, tc),
              32'({s2_cout, s2_ovf, s2_sum}), 32'({full[4], eo, full[3:0]}));
    endtask

    task automatic run88(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
        logic [8:0] full;
        logic       eo;
        logic [9:0] exp_v;
        full = {1'b0, ta} + {1'b0, tb_v} + {8'b0, tc};
        eo   = (ta[7] == tb_v[7]) && (full[7] != ta[7]);
        exp_q.push_back({full[8], eo, full[7:0]});
        s3_a = ta; s3_b = tb_v; s3_cin = tc; s3_start = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        check("w8d8 c1 busy/done", 32'({s3_busy, s3_done}), 32'(2'b10));
        @(negedge clk);
        check("w8d8 c2 busy/done", 32'({s3_busy, s3_done}), 32'(2'b01));
        exp_v = exp_q.pop_front();
        check($sformatf("w8d8 %h+%h+%b {cout,ovf,sum}", ta, tb_v, tc),
              32'({s3_cout, s3_ovf, s3_sum}), 32'(exp_v));
    endtask

    initial begin
        int done_cnt;
        vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, c: 1'b0, o: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1, o: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, c: 1'b0, o: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, c: 1'b1, o: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, c: 1'b1, o: 1'b1};
        vecs[5] = '{a: 8'h12, b: 8'h34, cin: 1'b0, s: 8'h46, c: 1'b0, o: 1'b0};
        vecs[6] = '{a: 8'h55, b: 8'hAA, cin: 1'b1, s: 8'h00, c: 1'b1, o: 1'b0};
        vecs[7] = '{a: 8'h40, b: 8'h40, cin: 1'b0, s: 8'h80, c: 1'b0, o: 1'b1};

        rst = 1'b1;
        s1_start = 0; s1_a = 0; s1_b = 0; s1_cin = 0;
        s2_start = 0; s2_a = 0; s2_b = 0; s2_cin = 0;
        s3_start = 0; s3_a = 0; s3_b = 0; s3_cin = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset w8 outputs", 32'({s1_busy, s1_done, s1_cout, s1_ovf, s1_sum}), 32'(0));
        check("reset w8 state", 32'(s1_state), 32'(0));
        check("reset w4 outputs", 32'({s2_busy, s2_done, s2_cout, s2_ovf, s2_sum}), 32'(0));
        check("reset w8d8 outputs", 32'({s3_busy, s3_done, s3_cout, s3_ovf, s3_sum}), 32'(0));
        rst = 1'b0;

        // Directed table; consecutive entries also start back-to-back from DONE.
        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, vecs[i].o);
        end

        // start held high through RUN: one done, then the DONE-cycle start is taken.
        @(negedge clk);
        s1_a = 8'h80; s1_b = 8'h80; s1_cin = 1'b0; s1_start = 1'b1;
        done_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            s1_a = 8'h01; s1_b = 8'h02;
            if (s1_done) done_cnt++;
            check($sformatf("hold busy c%0d", k), 32'(s1_busy), 32'(k <= 8));
        end
        check("hold done count", 32'(done_cnt), 32'(1));
        check("hold result", 32'({s1_cout, s1_ovf, s1_sum}), 32'({2'b11, 8'h00}));
        @(negedge clk);
        s1_start = 1'b0;
        check("done-cycle start accepted busy", 32'({s1_busy, s1_done}), 32'(2'b10));
        for (int k = 2; k <= 9; k++) @(negedge clk);
        check("second op done", 32'(s1_done), 32'(1));
        check("second op result", 32'({s1_cout, s1_ovf, s1_sum}), 32'({2'b00, 8'h03}));

        // Abort mid-run: start 12+34 in this DONE cycle, rst in cycle 4.
        s1_a = 8'h12; s1_b = 8'h34; s1_start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            s1_start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort outputs", 32'({s1_busy, s1_done, s1_cout, s1_ovf, s1_sum}), 32'(0));
        check("abort state", 32'(s1_state), 32'(0));
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (s1_done || s1_busy) done_cnt++;
        end
        check("abort no activity", 32'(done_cnt), 32'(0));

        // rst and start together: rst wins.
        s1_a = 8'hFF; s1_b = 8'h01; s1_start = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; s1_start = 1'b0;
        check("rst beats start busy", 32'(s1_busy), 32'(0));
        @(negedge clk);
        check("rst beats start idle", 32'({s1_busy, s1_state}), 32'(0));

        // Exhaustive 4-bit, 2-bit digits.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run4(4'(ia), 4'(ib), 1'(ic));
                end
            end
        end

        // Single-digit instance, back-to-back random operations.
        for (int i = 0; i < 1000; i++) begin
            run88(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        check("w8d8 returns to idle", 32'({s3_busy, s3_done, s3_state}), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
